// File: rtl/shift_exec_seq.sv
// Iterative shifter (SLL/SRL/SRA/PASS), one bit per clock, result held until writeback takes it.
// Latency: accept in cycle 0 -> out_valid in cycle k+1, k = min(shamt, DATA_W), 0 for PASS.
// Backpressure: result held while out_ready is low; in_ready is low from accept until the cycle after the handshake.
module shift_exec_seq #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  hyrja,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  dalja,
    output logic               busy
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // Amounts at or above the operand width behave exactly like a full-width shift.
    localparam logic [SHAMT_W-1:0] SHAMT_SAT = SHAMT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  work;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  work_sh;
    logic [SHAMT_W-1:0] k;

    // Gating with rst_n keeps decode from seeing ready while reset is held.
    assign in_ready = (state == IDLE) & rst_n;

    // Effective iteration count for the op being offered by decode.
    always_comb begin
        k = '0;
        if (op != OP_PASS) begin
            k = (shamt >= SHAMT_SAT) ? SHAMT_SAT : shamt;
        end
    end

    // One-bit step of the latched op; SRA replicates the sign bit to stay bit-exact with the combinational SRA.
    always_comb begin
        work_sh = work;
        case (op_q)
            OP_SLL:  work_sh = {work[DATA_W-2:0], 1'b0};
            OP_SRL:  work_sh = {1'b0, work[DATA_W-1:1]};
            OP_SRA:  work_sh = {work[DATA_W-1], work[DATA_W-1:1]};
            default: work_sh = work;
        endcase
    end

    // Control FSM with registered outputs; reset beats flush, flush beats every handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            op_q      <= OP_PASS;
            dalja     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            dalja     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= hyrja;
                        op_q <= op;
                        busy <= 1'b1;
                        if (k == '0) begin
                            state     <= DONE;
                            dalja     <= hyrja;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            cnt   <= k;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_sh;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        state     <= DONE;
                        dalja     <= work_sh;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // dalja keeps its value after the handshake; only the valid drops.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_exec_seq.sv
// Scoreboard bench for shift_exec_seq: expected result and latency queued at issue, checked on out_valid.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready stalls, flush and reset mid-operation.
module tb_shift_exec_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] hyrja;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dalja;
    logic        busy;

    localparam logic [1:0] SLL  = 2'b00;
    localparam logic [1:0] SRL  = 2'b01;
    localparam logic [1:0] SRA  = 2'b10;
    localparam logic [1:0] PASS = 2'b11;

    typedef struct {
        logic [15:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    shift_exec_seq #(.DATA_W(16), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .hyrja     (hyrja),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dalja     (dalja),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference result using native shift operators.
    function automatic logic [15:0] model_res(input logic [1:0] o, input logic [15:0] x, input logic [4:0] s);
        int               kk;
        logic signed [15:0] sx;
        kk = (s > 5'd16) ? 16 : int'(s);
        sx = x;
        case (o)
            SLL:     return x << kk;
            SRL:     return x >> kk;
            SRA:     return 16'(sx >>> kk);
            default: return x;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [4:0] s);
        if (o == PASS) return 1;
        return ((s > 5'd16) ? 16 : int'(s)) + 1;
    endfunction

    // Present an op in cycle 0, accept at the next edge, then scramble inputs.
    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [4:0] s);
        exp_t e;
        @(posedge clk); #1;
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        op       = o;
        hyrja    = x;
        shamt    = s;
        e.res    = model_res(o, x, s);
        e.lat    = model_lat(o, s);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = ~o;
        hyrja    = ~x;
        shamt    = s ^ 5'h0b;
        chk("busy_after_accept", busy, 1'b1);
        chk("in_ready_busy", in_ready, 1'b0);
    endtask

    // Bounded wait for out_valid; compare latency and data against the scoreboard head.
    task automatic wait_result(input string tag, output logic [15:0] res);
        int   lat;
        exp_t e;
        lat = 1;
        res = 16'h0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, out_valid, 1'b1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, 32'd0, 32'd1);
            return;
        end
        e   = sb.pop_front();
        res = e.res;
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_dalja"}, dalja, e.res);
    endtask

    // Full op with writeback always ready; verify return to idle afterwards.
    task automatic run(input string tag, input logic [1:0] o, input logic [15:0] x, input logic [4:0] s);
        logic [15:0] r;
        out_ready = 1'b1;
        issue(o, x, s);
        wait_result(tag, r);
        @(posedge clk); #1;
        chk({tag, "_busy_fall"}, busy, 1'b0);
        chk({tag, "_ov_fall"}, out_valid, 1'b0);
        chk({tag, "_dalja_keep"}, dalja, r);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] r;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = SLL;
        hyrja     = 16'h0;
        shamt     = 5'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dalja", dalja, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_in_ready", in_ready, 1'b1);

        // Basic ops, sign handling, saturation, zero-iteration paths
        run("sra90",    SRA,  16'd90,   5'd3);
        run("sra8000",  SRA,  16'h8000, 5'd3);
        run("srl8000",  SRL,  16'h8000, 5'd3);
        run("sll15",    SLL,  16'h0001, 5'd15);
        run("sra_sat",  SRA,  16'h8001, 5'd20);
        run("srl_sat",  SRL,  16'h8001, 5'd20);
        run("sll_16",   SLL,  16'hFFFF, 5'd16);
        run("sh0",      SLL,  16'h1234, 5'd0);
        run("pass",     PASS, 16'h1234, 5'd9);
        for (int i = 0; i < 6; i++) begin
            run("rand", 2'($urandom_range(0, 3)), 16'($urandom), 5'($urandom_range(0, 31)));
        end

        // Backpressure: result held, new in_valid ignored
        out_ready = 1'b0;
        issue(SLL, 16'h00F0, 5'd4);
        wait_result("bp", r);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op       = PASS;
            hyrja    = 16'hDEAD;
            @(posedge clk); #1;
            chk("bp_ov_hold", out_valid, 1'b1);
            chk("bp_dalja_hold", dalja, r);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_busy", busy, 1'b0);
        chk("bp_release_ov", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("bp_no_accept", out_valid | busy, 1'b0);

        // Flush at cycle 2 of an 8-bit shift
        out_ready = 1'b1;
        issue(SLL, 16'h00FF, 5'd8);
        @(posedge clk); #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        void'(sb.pop_front());
        chk("fl_ov", out_valid, 1'b0);
        chk("fl_dalja", dalja, 16'h0);
        chk("fl_busy", busy, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        run("after_fl", SRA, 16'hA5A5, 5'd5);

        // Flush beats a same-cycle out_ready in DONE
        out_ready = 1'b0;
        issue(PASS, 16'h1234, 5'd0);
        wait_result("fl_done", r);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_done_ov", out_valid, 1'b0);
        chk("fl_done_dalja", dalja, 16'h0);

        // Reset at cycle 2 of an 8-bit shift
        run("pre_rst", SRL, 16'hF00F, 5'd1);
        issue(SLL, 16'h00FF, 5'd8);
        @(posedge clk); #1;
        rst_n = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb.pop_front());
        chk("rs_ov", out_valid, 1'b0);
        chk("rs_dalja", dalja, 16'h0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_in_ready_low", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rs_in_ready", in_ready, 1'b1);
        run("after_rst", SLL, 16'h0003, 5'd14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
